// File: rtl/alu_decode_stage_pkg.sv
// Shared types for the decode/issue stage: ALU codes, datapath widths,
// MIPS opcode/funct values and the ID/EX entry layout.
package alu_decode_stage_pkg;

  typedef logic [31:0] DataPath;
  typedef logic [31:0] InsnPath;
  typedef logic [4:0]  RegNumPath;

  typedef enum logic [3:0] {
    ALU_CODE_ADD = 4'd0,
    ALU_CODE_SUB = 4'd1,
    ALU_CODE_AND = 4'd2,
    ALU_CODE_OR  = 4'd3,
    ALU_CODE_XOR = 4'd4,
    ALU_CODE_SLT = 4'd5,
    ALU_CODE_SLL = 4'd6,
    ALU_CODE_SRL = 4'd7
  } ALUCodePath;

  // The ALU takes its shift amount from B[10:6], matching the R-type shamt slot.
  localparam int SHIFT_FIELD_LSB = 6;
  localparam int SHIFT_FIELD_MSB = 10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // LUI is executed as imm << 16, so B carries 16 in its shift field.
  localparam DataPath LUI_SHIFT = 32'h0000_0400;

  typedef struct packed {
    ALUCodePath code;
    DataPath    a;
    DataPath    b;
    RegNumPath  wrNum;
    logic       wrEnable;
    logic       illegal;
  } IdExEntry;

  localparam IdExEntry ID_EX_RESET = '{
    code:     ALU_CODE_ADD,
    a:        32'h0,
    b:        32'h0,
    wrNum:    5'd0,
    wrEnable: 1'b0,
    illegal:  1'b0
  };

endpackage

// File: rtl/alu_decode_stage_decoder.sv
// Combinational instruction decoder: maps an instruction plus register
// read data onto ALU code, operands and write-back info.
module alu_insn_decoder
  import alu_decode_stage_pkg::*;
(
  input  InsnPath   insn,
  input  DataPath   rsData,
  input  DataPath   rtData,
  output RegNumPath rsNum,
  output RegNumPath rtNum,
  output IdExEntry  decoded
);

  logic [5:0] opcode;
  logic [5:0] funct;
  RegNumPath  rdNum;
  DataPath    immSext;
  DataPath    immZext;
  logic       legal;

  assign opcode  = insn[31:26];
  assign funct   = insn[5:0];
  assign rsNum   = insn[25:21];
  assign rtNum   = insn[20:16];
  assign rdNum   = insn[15:11];
  assign immSext = {{16{insn[15]}}, insn[15:0]};
  assign immZext = {16'h0000, insn[15:0]};

  always_comb begin
    decoded = ID_EX_RESET;
    legal   = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        decoded.a     = rsData;
        decoded.b     = rtData;
        decoded.wrNum = rdNum;
        case (funct)
          FN_SLL: begin
            decoded.code = ALU_CODE_SLL;
            decoded.a    = rtData;
            decoded.b    = immZext;
          end
          FN_SRL: begin
            decoded.code = ALU_CODE_SRL;
            decoded.a    = rtData;
            decoded.b    = immZext;
          end
          FN_ADD, FN_ADDU: decoded.code = ALU_CODE_ADD;
          FN_SUB, FN_SUBU: decoded.code = ALU_CODE_SUB;
          FN_AND:          decoded.code = ALU_CODE_AND;
          FN_OR:           decoded.code = ALU_CODE_OR;
          FN_XOR:          decoded.code = ALU_CODE_XOR;
          FN_SLT:          decoded.code = ALU_CODE_SLT;
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        decoded.code = ALU_CODE_ADD; decoded.a = rsData; decoded.b = immSext; decoded.wrNum = rtNum;
      end
      OP_SLTI: begin
        decoded.code = ALU_CODE_SLT; decoded.a = rsData; decoded.b = immSext; decoded.wrNum = rtNum;
      end
      OP_ANDI: begin
        decoded.code = ALU_CODE_AND; decoded.a = rsData; decoded.b = immZext; decoded.wrNum = rtNum;
      end
      OP_ORI: begin
        decoded.code = ALU_CODE_OR;  decoded.a = rsData; decoded.b = immZext; decoded.wrNum = rtNum;
      end
      OP_XORI: begin
        decoded.code = ALU_CODE_XOR; decoded.a = rsData; decoded.b = immZext; decoded.wrNum = rtNum;
      end
      OP_LUI: begin
        decoded.code = ALU_CODE_SLL; decoded.a = immZext; decoded.b = LUI_SHIFT; decoded.wrNum = rtNum;
      end
      default: legal = 1'b0;
    endcase

    // Undecodable words travel down the pipe as a harmless, flagged no-op.
    if (!legal) begin
      decoded         = ID_EX_RESET;
      decoded.illegal = 1'b1;
    end
    decoded.wrEnable = legal && (decoded.wrNum != 5'd0);
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode/issue stage: decodes one instruction per transfer into a single-entry
// ID/EX register with valid/ready handshake and synchronous flush.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [DATA_WIDTH-1:0]    insn,
  output logic [REG_NUM_WIDTH-1:0] rsNum,
  output logic [REG_NUM_WIDTH-1:0] rtNum,
  input  logic [DATA_WIDTH-1:0]    rsData,
  input  logic [DATA_WIDTH-1:0]    rtData,
  input  logic                     flush,
  output logic                     outValid,
  input  logic                     outReady,
  output ALUCodePath               aluCode,
  output logic [DATA_WIDTH-1:0]    aluInA,
  output logic [DATA_WIDTH-1:0]    aluInB,
  output logic [REG_NUM_WIDTH-1:0] wrNum,
  output logic                     wrEnable,
  output logic                     illegal
);

  IdExEntry decoded;
  IdExEntry entry_q, entry_d;
  logic     valid_q, valid_d;
  logic     accept;

  alu_insn_decoder u_decoder (
    .insn    (insn),
    .rsData  (rsData),
    .rtData  (rtData),
    .rsNum   (rsNum),
    .rtNum   (rtNum),
    .decoded (decoded)
  );

  assign inReady = !valid_q || outReady;
  assign accept  = inValid && inReady && !flush;

  // Retire and reload share one edge, so a ready consumer sees full throughput.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      entry_d = decoded;
    end else if (outReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      entry_q <= ID_EX_RESET;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign outValid = valid_q;
  assign aluCode  = entry_q.code;
  assign aluInA   = entry_q.a;
  assign aluInB   = entry_q.b;
  assign wrNum    = entry_q.wrNum;
  assign wrEnable = entry_q.wrEnable;
  assign illegal  = entry_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a queue-based behavioural model of the stage.
module tb_alu_decode_stage;
  import alu_decode_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid, inReady, flush, outValid, outReady;
  logic [31:0] insn, rsData, rtData, aluInA, aluInB;
  logic [4:0] rsNum, rtNum, wrNum;
  logic       wrEnable, illegal;
  ALUCodePath aluCode;

  int total = 0;
  int bad   = 0;

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .insn(insn),
    .rsNum(rsNum), .rtNum(rtNum), .rsData(rsData), .rtData(rtData), .flush(flush),
    .outValid(outValid), .outReady(outReady), .aluCode(aluCode), .aluInA(aluInA),
    .aluInB(aluInB), .wrNum(wrNum), .wrEnable(wrEnable), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decode written from the instruction-set rules, one mnemonic at a time.
  function automatic IdExEntry modelDecode(logic [31:0] w, logic [31:0] rs, logic [31:0] rt);
    IdExEntry e;
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    logic [31:0] sx = {{16{w[15]}}, w[15:0]};
    logic [31:0] zx = {16'h0, w[15:0]};
    logic ok = 1'b1;
    e = ID_EX_RESET;
    if (op == 6'h00) begin
      e.wrNum = w[15:11];
      if (fn == 6'h00 || fn == 6'h02) begin
        e.code = (fn == 6'h00) ? ALU_CODE_SLL : ALU_CODE_SRL;
        e.a = rt; e.b = zx;
      end else begin
        e.a = rs; e.b = rt;
        if (fn == 6'h20 || fn == 6'h21) e.code = ALU_CODE_ADD;
        else if (fn == 6'h22 || fn == 6'h23) e.code = ALU_CODE_SUB;
        else if (fn == 6'h24) e.code = ALU_CODE_AND;
        else if (fn == 6'h25) e.code = ALU_CODE_OR;
        else if (fn == 6'h26) e.code = ALU_CODE_XOR;
        else if (fn == 6'h2A) e.code = ALU_CODE_SLT;
        else ok = 1'b0;
      end
    end else if (op == 6'h0F) begin
      e.code = ALU_CODE_SLL; e.a = zx; e.b = 32'd16 << 6; e.wrNum = w[20:16];
    end else begin
      e.a = rs; e.wrNum = w[20:16];
      if (op == 6'h09) begin e.code = ALU_CODE_ADD; e.b = sx; end
      else if (op == 6'h0A) begin e.code = ALU_CODE_SLT; e.b = sx; end
      else if (op == 6'h0C) begin e.code = ALU_CODE_AND; e.b = zx; end
      else if (op == 6'h0D) begin e.code = ALU_CODE_OR;  e.b = zx; end
      else if (op == 6'h0E) begin e.code = ALU_CODE_XOR; e.b = zx; end
      else ok = 1'b0;
    end
    if (!ok) begin
      e = ID_EX_RESET;
      e.illegal = 1'b1;
    end
    e.wrEnable = ok && (e.wrNum != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] aluModel(ALUCodePath c, logic [31:0] a, logic [31:0] b);
    case (c)
      ALU_CODE_SLL: return a << b[10:6];
      ALU_CODE_SRL: return a >> b[10:6];
      ALU_CODE_SUB: return a - b;
      ALU_CODE_AND: return a & b;
      ALU_CODE_OR:  return a | b;
      ALU_CODE_XOR: return a ^ b;
      ALU_CODE_SLT: return {31'd0, $signed(a) < $signed(b)};
      default:      return a + b;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] w, logic [31:0] rs, logic [31:0] rt,
                               logic rdy, logic fl);
    @(negedge clk);
    #1;
    inValid = v; insn = w; rsData = rs; rtData = rt; outReady = rdy; flush = fl;
  endtask

  // Model: a one-slot queue plus the last entry shown on the data outputs.
  IdExEntry slot[$];
  IdExEntry shown = ID_EX_RESET;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot.delete();
      shown = ID_EX_RESET;
    end else if (flush) begin
      slot.delete();
    end else begin
      logic canTake;
      canTake = (slot.size() == 0) || outReady;
      if (slot.size() != 0 && outReady) void'(slot.pop_front());
      if (inValid && canTake) begin
        shown = modelDecode(insn, rsData, rtData);
        slot.push_back(shown);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("outValid", {31'd0, outValid}, {31'd0, slot.size() != 0});
    checkOutput("inReady",  {31'd0, inReady},  {31'd0, (slot.size() == 0) || outReady});
    checkOutput("rsNum",    {27'd0, rsNum},    {27'd0, insn[25:21]});
    checkOutput("rtNum",    {27'd0, rtNum},    {27'd0, insn[20:16]});
    checkOutput("aluCode",  32'(aluCode),      32'(shown.code));
    checkOutput("aluInA",   aluInA,            shown.a);
    checkOutput("aluInB",   aluInB,            shown.b);
    checkOutput("wrNum",    {27'd0, wrNum},    {27'd0, shown.wrNum});
    checkOutput("wrEnable", {31'd0, wrEnable}, {31'd0, shown.wrEnable});
    checkOutput("illegal",  {31'd0, illegal},  {31'd0, shown.illegal});
  end

  function automatic logic [31:0] randomInsn();
    logic [31:0] w;
    logic [5:0] ops[8];
    logic [5:0] fns[11];
    ops = '{6'h00, 6'h00, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    fns = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2A};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[31:26] = ops[$urandom_range(0, 7)];
    if (w[31:26] == 6'h00 && $urandom_range(0, 9) != 0) w[5:0] = fns[$urandom_range(0, 10)];
    return w;
  endfunction

  logic [31:0] snapA, snapB;

  initial begin
    rst = 1'b0; inValid = 1'b0; insn = 32'h0; rsData = 32'h0; rtData = 32'h0;
    outReady = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst outValid", {31'd0, outValid}, 32'd0);
    checkOutput("rst aluCode", 32'(aluCode), 32'(ALU_CODE_ADD));
    checkOutput("rst aluInA", aluInA, 32'd0);
    checkOutput("rst wrEnable", {31'd0, wrEnable}, 32'd0);
    #1 rst = 1'b1;

    applyStimulus(1'b1, 32'h2422FFFF, 32'd5, 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("addiu valid", {31'd0, outValid}, 32'd1);
    checkOutput("addiu code", 32'(aluCode), 32'(ALU_CODE_ADD));
    checkOutput("addiu A", aluInA, 32'd5);
    checkOutput("addiu B", aluInB, 32'hFFFFFFFF);
    checkOutput("addiu wrNum", {27'd0, wrNum}, 32'd2);
    checkOutput("addiu wrEn", {31'd0, wrEnable}, 32'd1);

    applyStimulus(1'b1, 32'h3C031234, 32'd9, 32'd9, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("lui code", 32'(aluCode), 32'(ALU_CODE_SLL));
    checkOutput("lui A", aluInA, 32'h00001234);
    checkOutput("lui B", aluInB, 32'h00000400);
    checkOutput("lui wrNum", {27'd0, wrNum}, 32'd3);
    checkOutput("lui result", aluModel(aluCode, aluInA, aluInB), 32'h12340000);

    applyStimulus(1'b1, 32'h00021100, 32'd0, 32'd3, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("sll A", aluInA, 32'd3);
    checkOutput("sll B", aluInB, 32'h1100);
    checkOutput("sll shamt", {27'd0, aluInB[SHIFT_FIELD_MSB:SHIFT_FIELD_LSB]}, 32'd4);
    checkOutput("sll wrNum", {27'd0, wrNum}, 32'd2);
    checkOutput("sll result", aluModel(aluCode, aluInA, aluInB), 32'h30);

    snapA = aluInA; snapB = aluInB;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("stall inReady", {31'd0, inReady}, 32'd0);
      checkOutput("stall valid", {31'd0, outValid}, 32'd1);
      checkOutput("stall A", aluInA, snapA);
      checkOutput("stall B", aluInB, snapB);
    end
    for (int k = 4; k < 8; k++) begin
      applyStimulus(1'b1, {6'h09, 5'd1, 5'(k), 16'(k)}, 32'd100, 32'd0, 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("stream wrNum", {27'd0, wrNum}, k);
      checkOutput("stream A+B", aluInA + aluInB, 32'd100 + k);
    end

    applyStimulus(1'b1, 32'hFC000000, 32'd1, 32'd1, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("flush valid", {31'd0, outValid}, 32'd0);
    checkOutput("flush hold wrNum", {27'd0, wrNum}, 32'd7);
    applyStimulus(1'b1, 32'hFC000000, 32'd1, 32'd1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("illegal flag", {31'd0, illegal}, 32'd1);
    checkOutput("illegal wrEn", {31'd0, wrEnable}, 32'd0);
    checkOutput("illegal A", aluInA, 32'd0);

    applyStimulus(1'b1, 32'h00220020, 32'd7, 32'd8, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("r0 wrEn", {31'd0, wrEnable}, 32'd0);
    checkOutput("r0 A", aluInA, 32'd7);

    applyStimulus(1'b1, 32'h24450011, 32'd1, 32'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h24450012, 32'd1, 32'd1, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst valid", {31'd0, outValid}, 32'd0);
    checkOutput("async rst wrNum", {27'd0, wrNum}, 32'd0);
    @(negedge clk); #1 rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 9) < 7, randomInsn(), $urandom, $urandom,
                    $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
